// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 asynchronous serial receiver, LSB first.
// Synchronises the raw receive pin, recovers one byte per frame and holds it
// for the downstream command consumer, flagging framing errors and overruns.
//
// Handshake: rx_valid is a level that stays high while rx_data holds an
// unconsumed byte; a byte is consumed on any rising edge where
// rx_valid && rx_ready, and rx_valid drops on the following cycle. rx_ready is
// ignored while rx_valid is low. When a consume and a frame completion land on
// the same edge the consume is applied first, so the new byte is loaded,
// rx_valid stays high and no overrun is raised.
module uart_rx_byte #(
   parameter int CLKS_PER_BIT = 87
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       uart_rxd,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   // Half a bit period: the start bit is validated in its middle, which puts
   // every later sample one full bit period further on, near mid-bit.
   localparam int          HALF      = CLKS_PER_BIT / 2;
   localparam logic [15:0] HALF_LAST = 16'(HALF - 1);
   localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_WAIT_HI
   } state_t;

   state_t      state;
   logic        rx_meta;
   logic        rx_s;
   logic [15:0] cnt;
   logic [2:0]  idx;
   logic [7:0]  sh;

   // Consume is resolved before frame completion on the same edge.
   logic consume;
   logic valid_after_consume;

   assign consume             = rx_valid & rx_ready;
   assign valid_after_consume = rx_valid & ~rx_ready;

   // Two-flop synchroniser for the asynchronous pin; idles high like the line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= uart_rxd;
         rx_s    <= rx_meta;
      end
   end

   // Frame FSM with the output byte, handshake and status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         cnt       <= 16'd0;
         idx       <= 3'd0;
         sh        <= 8'h00;
         rx_data   <= 8'h00;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         frame_err <= 1'b0;

         if (consume) begin
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
         end

         case (state)
            S_IDLE: begin
               if (!rx_s) begin
                  state <= S_START;
                  cnt   <= 16'd0;
                  busy  <= 1'b1;
               end
            end

            S_START: begin
               if (cnt == HALF_LAST) begin
                  cnt <= 16'd0;
                  if (!rx_s) begin
                     state <= S_DATA;
                     idx   <= 3'd0;
                  end else begin
                     // Line went back high before mid start bit: a glitch.
                     state <= S_IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end

            S_DATA: begin
               if (cnt == BIT_LAST) begin
                  cnt <= 16'd0;
                  sh  <= {rx_s, sh[7:1]};
                  if (idx == 3'd7) begin
                     state <= S_STOP;
                  end else begin
                     idx <= idx + 3'd1;
                  end
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end

            S_STOP: begin
               if (cnt == BIT_LAST) begin
                  cnt <= 16'd0;
                  if (rx_s) begin
                     if (!valid_after_consume) begin
                        rx_data  <= sh;
                        rx_valid <= 1'b1;
                     end else begin
                        // Previous byte still pending: drop the new one.
                        overrun <= 1'b1;
                     end
                     state <= S_IDLE;
                     busy  <= 1'b0;
                  end else begin
                     frame_err <= 1'b1;
                     state     <= S_WAIT_HI;
                  end
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end

            S_WAIT_HI: begin
               // A held-low line (break) must not decode as repeated 0x00.
               if (rx_s) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            end

            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte: directed and randomized stimulus for uart_rx_byte, checked
// every cycle against a timestamp-based frame model of the receiver.
module tb_uart_rx_byte;

   localparam int CPB  = 8;
   localparam int HALF = CPB / 2;

   // ---------------- clock / reset ----------------
   logic       clk      = 1'b0;
   logic       rst_n    = 1'b0;
   logic       uart_rxd = 1'b1;
   logic       rx_ready = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   always #5 clk = ~clk;

   uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .uart_rxd  (uart_rxd),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .frame_err (frame_err),
      .overrun   (overrun),
      .busy      (busy)
   );

   // ---------------- counters ----------------
   int chk_cnt  = 0;
   int pass_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   // The pin reaches the decision logic two edges late. Once a low is seen
   // while idle at edge t0, every later decision happens at a fixed offset
   // from t0; the byte is assembled from the recorded sampled-line history.
   typedef enum int {M_IDLE, M_RX, M_WAIT} mmode_t;

   mmode_t     m_mode;
   logic       m_p1, m_p2, m_rs;
   logic       rxs_h [0:16383];
   int         cyc = 0;
   int         t0  = 0;
   logic [7:0] m_byte;
   logic [7:0] m_data;
   logic       m_valid, m_ferr, m_ovr;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_p1    = 1'b1;
         m_p2    = 1'b1;
         m_mode  = M_IDLE;
         m_data  = 8'h00;
         m_valid = 1'b0;
         m_ferr  = 1'b0;
         m_ovr   = 1'b0;
      end else begin
         m_rs = m_p2;
         m_p2 = m_p1;
         m_p1 = uart_rxd;
         rxs_h[cyc % 16384] = m_rs;
         m_ferr = 1'b0;
         if (m_valid && rx_ready) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
         end
         case (m_mode)
            M_IDLE: if (!m_rs) begin
               t0     = cyc;
               m_mode = M_RX;
            end
            M_RX: begin
               if (cyc == t0 + HALF && m_rs) begin
                  m_mode = M_IDLE;
               end else if (cyc == t0 + HALF + 9 * CPB) begin
                  for (int k = 0; k < 8; k++)
                     m_byte[k] = rxs_h[(t0 + HALF + (k + 1) * CPB) % 16384];
                  if (m_rs) begin
                     if (!m_valid) begin
                        m_data  = m_byte;
                        m_valid = 1'b1;
                     end else begin
                        m_ovr = 1'b1;
                     end
                     m_mode = M_IDLE;
                  end else begin
                     m_ferr = 1'b1;
                     m_mode = M_WAIT;
                  end
               end
            end
            M_WAIT: if (m_rs) m_mode = M_IDLE;
            default: m_mode = M_IDLE;
         endcase
         cyc++;
      end
   end

   // Compare every cycle, away from the active edge.
   always @(negedge clk) begin
      chk("rx_valid",  32'(rx_valid),  32'(m_valid));
      chk("rx_data",   32'(rx_data),   32'(m_data));
      chk("frame_err", 32'(frame_err), 32'(m_ferr));
      chk("overrun",   32'(overrun),   32'(m_ovr));
      chk("busy",      32'(busy),      32'(m_mode != M_IDLE));
   end

   // ---------------- driver tasks ----------------
   task automatic send_frame(input logic [7:0] b, input logic stop);
      uart_rxd = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
         uart_rxd = b[k];
         repeat (CPB) @(negedge clk);
      end
      uart_rxd = stop;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic idle(input int n);
      uart_rxd = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_ready();
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
   endtask

   // ---------------- scoreboard state ----------------
   logic [7:0] exp_q[$];
   int         nv;
   int         cnt_l;
   bit         rnd_done;

   // ---------------- stimulus ----------------
   initial begin
      repeat (3) @(negedge clk);
      chk("reset_valid", 32'(rx_valid), 32'd0);
      chk("reset_data",  32'(rx_data),  32'h00);
      chk("reset_busy",  32'(busy),     32'd0);
      rst_n = 1'b1;
      idle(4);

      // Single byte 0xA5, stop sample lands 78 edges after the start edge.
      uart_rxd = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
         uart_rxd = (8'hA5 >> k) & 8'h01;
         repeat (CPB) @(negedge clk);
      end
      uart_rxd = 1'b1;
      repeat (6) @(negedge clk);
      chk("a5_not_yet_valid", 32'(rx_valid), 32'd0);
      @(negedge clk);
      chk("a5_valid",   32'(rx_valid),  32'd1);
      chk("a5_data",    32'(rx_data),   32'hA5);
      chk("a5_ferr",    32'(frame_err), 32'd0);
      chk("a5_overrun", 32'(overrun),   32'd0);
      pulse_ready();
      chk("a5_consumed", 32'(rx_valid), 32'd0);
      idle(8);

      // Back-to-back 0x00, 0xFF with ready tied high.
      rx_ready = 1'b1;
      exp_q.push_back(8'h00);
      exp_q.push_back(8'hFF);
      nv = 0;
      fork
         begin
            send_frame(8'h00, 1'b1);
            send_frame(8'hFF, 1'b1);
            idle(20);
         end
         begin
            repeat (180) begin
               @(negedge clk);
               if (rx_valid) begin
                  nv++;
                  if (exp_q.size() == 0) chk("b2b_extra_byte", 32'(rx_data), 32'hFFFF);
                  else chk("b2b_data", 32'(rx_data), 32'(exp_q.pop_front()));
               end
            end
         end
      join
      rx_ready = 1'b0;
      chk("b2b_valid_cycles", 32'(nv), 32'd2);
      chk("b2b_queue_drained", 32'(exp_q.size()), 32'd0);
      idle(4);

      // Glitch: 3 cycles low keeps busy up for exactly HALF cycles.
      uart_rxd = 1'b0;
      repeat (3) @(negedge clk);
      uart_rxd = 1'b1;
      cnt_l = busy ? 1 : 0;
      repeat (12) begin
         @(negedge clk);
         if (busy) cnt_l++;
      end
      chk("glitch_busy_cycles", 32'(cnt_l), 32'(HALF));
      chk("glitch_no_valid",    32'(rx_valid), 32'd0);

      // Framing error then a long low line.
      cnt_l = 0;
      fork
         begin
            send_frame(8'h3C, 1'b0);
            uart_rxd = 1'b0;
            repeat (20 * CPB) @(negedge clk);
         end
         begin
            repeat (80 + 20 * CPB) begin
               @(negedge clk);
               if (frame_err) cnt_l++;
            end
         end
      join
      chk("ferr_pulses",     32'(cnt_l),    32'd1);
      chk("ferr_busy_low",   32'(busy),     32'd1);
      chk("ferr_no_valid",   32'(rx_valid), 32'd0);
      idle(4);
      chk("ferr_busy_clear", 32'(busy),     32'd0);
      idle(8);
      send_frame(8'h55, 1'b1);
      chk("after_ferr_valid", 32'(rx_valid), 32'd1);
      chk("after_ferr_data",  32'(rx_data),  32'h55);
      pulse_ready();

      // Overrun: second byte dropped while the first is pending.
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      idle(2);
      chk("ovr_data",  32'(rx_data),  32'h11);
      chk("ovr_flag",  32'(overrun),  32'd1);
      chk("ovr_valid", 32'(rx_valid), 32'd1);
      pulse_ready();
      chk("ovr_valid_cleared", 32'(rx_valid), 32'd0);
      chk("ovr_flag_cleared",  32'(overrun),  32'd0);
      idle(4);

      // Reset during data bit 4 of 0x96, with a pending byte in the holder.
      send_frame(8'h33, 1'b1);
      uart_rxd = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         uart_rxd = (8'h96 >> k) & 8'h01;
         repeat (CPB) @(negedge clk);
      end
      uart_rxd = (8'h96 >> 4) & 8'h01;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_data",    32'(rx_data),   32'h00);
      chk("rst_valid",   32'(rx_valid),  32'd0);
      chk("rst_busy",    32'(busy),      32'd0);
      chk("rst_ferr",    32'(frame_err), 32'd0);
      chk("rst_overrun", 32'(overrun),   32'd0);
      uart_rxd = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      idle(2 * CPB);
      send_frame(8'h96, 1'b1);
      chk("rst_recover_valid", 32'(rx_valid), 32'd1);
      chk("rst_recover_data",  32'(rx_data),  32'h96);
      pulse_ready();
      idle(4);

      // Randomized traffic: gaps, glitches, bad stop bits, random ready.
      rnd_done = 1'b0;
      fork
         begin
            for (int f = 0; f < 40; f++) begin
               idle($urandom_range(0, 12));
               if ($urandom_range(0, 5) == 0) begin
                  uart_rxd = 1'b0;
                  repeat ($urandom_range(1, HALF - 1)) @(negedge clk);
                  idle($urandom_range(0, 10));
               end
               if ($urandom_range(0, 7) == 0) begin
                  send_frame(8'($urandom_range(0, 255)), 1'b0);
                  uart_rxd = 1'b0;
                  repeat ($urandom_range(0, 24)) @(negedge clk);
                  uart_rxd = 1'b1;
               end else begin
                  send_frame(8'($urandom_range(0, 255)), 1'b1);
               end
            end
            idle(20);
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               rx_ready = ($urandom_range(0, 3) == 0);
               @(negedge clk);
            end
         end
      join
      rx_ready = 1'b0;
      idle(5);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
